// File: rtl/tile_spawner_if.sv
// Spawn request / board write bundle between the game controller, the random
// generator and the tile spawner.
interface tile_spawner_if;
    logic        spawn_req;
    logic        spawn_two;
    logic [63:0] board;
    logic [1:0]  xCoor;
    logic [1:0]  yCoor;
    logic        rndNum;
    logic        spawn_busy;
    logic        wr_en;
    logic [1:0]  wr_x;
    logic [1:0]  wr_y;
    logic [3:0]  wr_val;
    logic        spawn_done;
    logic        no_space;

    modport master (
        output spawn_req, spawn_two, board, xCoor, yCoor, rndNum,
        input  spawn_busy, wr_en, wr_x, wr_y, wr_val, spawn_done, no_space
    );

    modport slave (
        input  spawn_req, spawn_two, board, xCoor, yCoor, rndNum,
        output spawn_busy, wr_en, wr_x, wr_y, wr_val, spawn_done, no_space
    );
endinterface

// File: rtl/tile_spawner.sv
// Places one or two new tiles on the 4x4 board: random probes first, then a
// deterministic ascending scan so every placement finishes in bounded time.
module tile_spawner #(
    parameter int MAX_TRIES = 8,
    parameter int FOUR_BITS = 3
) (
    input logic           clk,
    input logic           rst_n,
    tile_spawner_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, PROBE, SCAN, WRITE, DONE} state_t;

    state_t               state;
    logic [15:0]          mask;
    logic [15:0]          free;
    logic [3:0]           tries;
    logic [3:0]           scan_idx;
    logic [1:0]           remaining;
    logic [FOUR_BITS-1:0] rnd_hist;
    logic                 ns_latch;
    logic [3:0]           probe_idx;
    logic [3:0]           pick_val;

    // The mask covers our own writes, which the board may not show until after done.
    always_comb begin
        free = '0;
        for (int i = 0; i < 16; i++)
            free[i] = (bus.board[i*4 +: 4] == 4'd0) && !mask[i];
    end

    assign probe_idx = {bus.yCoor, bus.xCoor};
    assign pick_val  = (&rnd_hist) ? 4'd2 : 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mask           <= '0;
            tries          <= '0;
            scan_idx       <= '0;
            remaining      <= '0;
            rnd_hist       <= '0;
            ns_latch       <= 1'b0;
            bus.spawn_busy <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_x       <= '0;
            bus.wr_y       <= '0;
            bus.wr_val     <= '0;
            bus.spawn_done <= 1'b0;
            bus.no_space   <= 1'b0;
        end else begin
            rnd_hist       <= (rnd_hist << 1) | FOUR_BITS'(bus.rndNum);
            bus.wr_en      <= 1'b0;
            bus.spawn_done <= 1'b0;
            bus.no_space   <= 1'b0;
            case (state)
                IDLE: begin
                    // The done pulse is still visible here; a request in that cycle is dropped.
                    if (bus.spawn_req && !bus.spawn_done) begin
                        remaining      <= bus.spawn_two ? 2'd2 : 2'd1;
                        mask           <= '0;
                        bus.spawn_busy <= 1'b1;
                        state          <= CHECK;
                    end else begin
                        bus.spawn_busy <= 1'b0;
                    end
                end
                CHECK: begin
                    tries <= '0;
                    if (free == 16'd0) begin
                        ns_latch <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= PROBE;
                    end
                end
                PROBE: begin
                    if (free[probe_idx]) begin
                        bus.wr_x   <= bus.xCoor;
                        bus.wr_y   <= bus.yCoor;
                        bus.wr_val <= pick_val;
                        state      <= WRITE;
                    end else if (tries == 4'(MAX_TRIES - 1)) begin
                        scan_idx <= '0;
                        state    <= SCAN;
                    end else begin
                        tries <= tries + 4'd1;
                    end
                end
                SCAN: begin
                    if (free[scan_idx]) begin
                        bus.wr_x   <= scan_idx[1:0];
                        bus.wr_y   <= scan_idx[3:2];
                        bus.wr_val <= pick_val;
                        state      <= WRITE;
                    end else begin
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
                WRITE: begin
                    bus.wr_en                  <= 1'b1;
                    mask[{bus.wr_y, bus.wr_x}] <= 1'b1;
                    remaining                  <= remaining - 2'd1;
                    state                      <= (remaining == 2'd1) ? DONE : CHECK;
                end
                DONE: begin
                    bus.spawn_done <= 1'b1;
                    bus.no_space   <= ns_latch;
                    ns_latch       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tile_spawner.md
Name: tile_spawner

Overview:
- Consumes the free-running pseudo-random coordinate/value stream (xCoor, yCoor, rndNum) and places one or two new tiles on the 4x4 2048 board after each move or at game start.
- Sits between the random generator and the board register file. It picks an empty cell, bounds its search with a deterministic fallback scan, and issues a single-cycle write per tile.

Parameters:
- MAX_TRIES, 8: random probes allowed per tile before switching to the linear fallback scan (1..15).
- FOUR_BITS, 3: length of the rndNum history. The tile is a "4" only if all FOUR_BITS samples are 1 (P = 1/8 by default).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- spawn_req  in  1  single-cycle request, accepted only in IDLE
- spawn_two  in  1  sampled with spawn_req; 1 = place two tiles (game start)
- board  in  64  16 cells x 4-bit exponent, cell idx = y*4+x at board[idx*4+3:idx*4]; 0 = empty; must be held stable while spawn_busy=1
- xCoor  in  2  random column from the generator
- yCoor  in  2  random row from the generator
- rndNum  in  1  random bit from the generator
- spawn_busy  out  1  high from the cycle after acceptance through the DONE cycle
- wr_en  out  1  single-cycle board write strobe
- wr_x  out  2  write column
- wr_y  out  2  write row
- wr_val  out  4  exponent to write: 1 = tile 2, 2 = tile 4
- spawn_done  out  1  single-cycle completion pulse
- no_space  out  1  pulses together with spawn_done when a required tile could not be placed

Behaviour:
- Reset (async assert, sync deassert is upstream's job):
  - state = IDLE.
  - All outputs = 0.
  - Internal mask, try counter, scan index, remaining count and rnd history = 0.
  - Reset mid-operation abandons the request with no further wr_en.
- Occupancy: cell is free iff board exponent == 0 AND its mask bit == 0. The mask records cells written during the current request, because board may not reflect our writes until after spawn_done.
- rnd history: shift register, shifts in rndNum every clock in all states.
- IDLE:
  - On spawn_req: remaining = spawn_two ? 2 : 1; mask = 0; go to CHECK.
  - spawn_req asserted in any other state is ignored; no queuing.
- CHECK (1 cycle):
  - tries = 0.
  - If no free cell exists: no_space latched, go to DONE.
  - Otherwise go to PROBE.
- PROBE (1 cycle per probe):
  - Samples xCoor/yCoor.
  - Free cell: latch wr_x/wr_y; wr_val = (&rnd_hist) ? 2 : 1 using the history as registered that cycle; go to WRITE.
  - Occupied cell: tries++. When tries reaches MAX_TRIES, set scan index = 0 and go to SCAN.
- SCAN: tests cell index 0..15, one per cycle, in ascending order.
  - The first free cell is latched (x = idx[1:0], y = idx[3:2]), wr_val chosen as in PROBE, go to WRITE.
  - CHECK guarantees a free cell exists, so index wrap never occurs.
- WRITE (1 cycle):
  - wr_en = 1 with the latched wr_x/wr_y/wr_val.
  - Set the mask bit; remaining--.
  - If remaining != 0, go to CHECK; else go to DONE.
- DONE (1 cycle):
  - spawn_done = 1; no_space = 1 if latched.
  - Clear the latch and return to IDLE.
  - A spawn_req in this cycle is ignored.
- Outputs are registered. wr_x/wr_y/wr_val hold their last values outside WRITE, but are only meaningful while wr_en = 1.
- Latency, best case (spawn_req sampled at edge N):
  - CHECK at N+1, PROBE hit at N+2.
  - wr_en high in the cycle after edge N+3.
  - spawn_done in the cycle after edge N+4.
- Worst case per tile: 1 + MAX_TRIES + 16 + 1 cycles.
- spawn_two on a board with exactly one free cell: first tile written, second CHECK finds none, so no_space = 1 and spawn_done = 1.

Test Plan:
1. Empty board, spawn_req, spawn_two = 0, xCoor = 1, yCoor = 2, rndNum = 0 -> exactly one wr_en with wr_x = 1, wr_y = 2, wr_val = 1; spawn_done one cycle later; no_space = 0.
2. Board full except cell (x=2, y=3); generator forced to (0,0); MAX_TRIES = 4 -> 4 failed probes, scan reaches idx 14 -> wr_en with x = 2, y = 3; total 1 + 4 + 15 + 1 cycles to wr_en.
3. Full board, spawn_req -> no wr_en, spawn_done and no_space high in the same single cycle, spawn_busy low after.
4. Empty board, spawn_two = 1, generator stuck at (3,3) -> first write at (3,3); second tile masked from (3,3), falls back to (0,0); two wr_en pulses, one spawn_done.
5. rndNum held 1 for 3+ cycles before the hit -> wr_val = 2; rndNum toggling 1,0,1 -> wr_val = 1.
6. rst_n pulled low during PROBE -> all outputs 0 immediately. After release, a spawn_req pulsed while busy is ignored (one wr_en only).
